// File: rtl/inv_addkey_mixcol_if.sv
`default_nettype none
// ============================================================================
//  Module      : inv_addkey_mixcol_if
//  Description : Block-level bus for inv_addkey_mixcol. Carries the upstream
//                valid/ready handshake with state, round key and last-round
//                flag, and the downstream valid/ready handshake with the
//                round result.
//                  master : producer/consumer side (drives inValid, state,
//                           roundKey, lastRound, outReady)
//                  slave  : round engine side (drives inReady, outValid,
//                           nextState)
//  Revision    : 1.0  initial release
// ============================================================================
interface inv_addkey_mixcol_if;
  logic         inValid;
  logic         inReady;
  logic [127:0] state;
  logic [127:0] roundKey;
  logic         lastRound;
  logic         outValid;
  logic         outReady;
  logic [127:0] nextState;

  modport master (
    output inValid, state, roundKey, lastRound, outReady,
    input  inReady, outValid, nextState
  );

  modport slave (
    input  inValid, state, roundKey, lastRound, outReady,
    output inReady, outValid, nextState
  );
endinterface
`default_nettype wire

// File: rtl/inv_addkey_mixcol.sv
`default_nettype none
// ============================================================================
//  Module      : inv_addkey_mixcol
//  Description : Decrypt-round back end. XORs the round key into the
//                InvSubByte output, then applies InvMixColumns column-serially
//                (COLS_PER_CYCLE columns per clock). On the final round the
//                mix is skipped and state^key is returned. One block in flight.
//  Ports       : clk        - clock, all flops on posedge
//                reset      - asynchronous active-high reset
//                bus.slave  - inValid/inReady/state/roundKey/lastRound in,
//                             outValid/outReady/nextState out
//                Byte s[r][c] = data[127-32c-8r -: 8].
//  Revision    : 1.0  initial release
// ============================================================================
module inv_addkey_mixcol #(
  parameter int COLS_PER_CYCLE = 1   // 1, 2 or 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  inv_addkey_mixcol_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MIX  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter step; 4 columns per cycle wraps to 0, which is harmless because
  // the block leaves MIX on that same edge.
  localparam logic [1:0] C_STEP = 2'(COLS_PER_CYCLE % 4);
  // Counter value at which this cycle's columns include column 3.
  localparam logic [1:0] C_LAST = 2'(4 - COLS_PER_CYCLE);

  logic [1:0]   fsm_q, fsm_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] next_state_q, next_state_d;
  logic         out_valid_q, out_valid_d;

  // GF(2^8) helpers, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] x9 [4];
    logic [7:0] xb [4];
    logic [7:0] xd [4];
    logic [7:0] xe [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xtime(a[r]);
      m4[r] = xtime(m2[r]);
      m8[r] = xtime(m4[r]);
      x9[r] = m8[r] ^ a[r];
      xb[r] = m8[r] ^ m2[r] ^ a[r];
      xd[r] = m8[r] ^ m4[r] ^ a[r];
      xe[r] = m8[r] ^ m4[r] ^ m2[r];
    end
    return {xe[0] ^ xb[1] ^ xd[2] ^ x9[3],
            x9[0] ^ xe[1] ^ xb[2] ^ xd[3],
            xd[0] ^ x9[1] ^ xe[2] ^ xb[3],
            xb[0] ^ xd[1] ^ x9[2] ^ xe[3]};
  endfunction

  assign bus.inReady   = (fsm_q == S_IDLE);
  assign bus.outValid  = out_valid_q;
  assign bus.nextState = next_state_q;

  // Columns are independent, so the mix is done in place in the work
  // register: each column is read and rewritten in the same cycle.
  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    next_state_d = next_state_q;
    out_valid_d  = out_valid_q;
    case (fsm_q)
      S_IDLE: begin
        if (bus.inValid) begin
          work_d = bus.state ^ bus.roundKey;
          cnt_d  = 2'd0;
          if (bus.lastRound) begin
            next_state_d = bus.state ^ bus.roundKey;
            out_valid_d  = 1'b1;
            fsm_d        = S_DONE;
          end else begin
            fsm_d = S_MIX;
          end
        end
      end
      S_MIX: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          logic [1:0] col_idx;
          logic [6:0] base;
          col_idx = cnt_q + 2'(k);
          base    = 7'd127 - {col_idx, 5'd0};
          work_d[base -: 32] = inv_mix_col(work_q[base -: 32]);
        end
        cnt_d = cnt_q + C_STEP;
        if (cnt_q == C_LAST) begin
          next_state_d = work_d;
          out_valid_d  = 1'b1;
          fsm_d        = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.outReady) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end
      default: begin
        fsm_d       = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= S_IDLE;
      cnt_q        <= 2'd0;
      work_q       <= '0;
      next_state_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      next_state_q <= next_state_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_addkey_mixcol.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_addkey_mixcol
//  Description : Directed self-checking bench for inv_addkey_mixcol with
//                three instances (COLS_PER_CYCLE = 1, 2, 4) sharing clock,
//                reset and input data; each has its own handshake lines.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inv_addkey_mixcol;

  logic         clk;
  logic         reset;
  logic [127:0] st;
  logic [127:0] key;
  logic         last;
  logic         in_valid   [3];
  logic         out_ready  [3];
  logic         in_ready   [3];
  logic         out_valid  [3];
  logic [127:0] next_state [3];

  int errors;
  int checks;

  localparam logic [127:0] C_ST2  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] C_EXP2 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] C_ST4  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C_KEY4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] C_EXP4 = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

  inv_addkey_mixcol_if ifc0 ();
  inv_addkey_mixcol_if ifc1 ();
  inv_addkey_mixcol_if ifc2 ();

  assign ifc0.inValid = in_valid[0];  assign ifc1.inValid = in_valid[1];  assign ifc2.inValid = in_valid[2];
  assign ifc0.outReady = out_ready[0]; assign ifc1.outReady = out_ready[1]; assign ifc2.outReady = out_ready[2];
  assign ifc0.state = st;      assign ifc1.state = st;      assign ifc2.state = st;
  assign ifc0.roundKey = key;  assign ifc1.roundKey = key;  assign ifc2.roundKey = key;
  assign ifc0.lastRound = last; assign ifc1.lastRound = last; assign ifc2.lastRound = last;
  assign in_ready[0] = ifc0.inReady;  assign in_ready[1] = ifc1.inReady;  assign in_ready[2] = ifc2.inReady;
  assign out_valid[0] = ifc0.outValid; assign out_valid[1] = ifc1.outValid; assign out_valid[2] = ifc2.outValid;
  assign next_state[0] = ifc0.nextState; assign next_state[1] = ifc1.nextState; assign next_state[2] = ifc2.nextState;

  inv_addkey_mixcol #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(ifc0.slave));
  inv_addkey_mixcol #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset(reset), .bus(ifc1.slave));
  inv_addkey_mixcol #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset(reset), .bus(ifc2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one block to instance sel, checks latency and result, holds
  // outReady low for hold_i cycles in DONE (offering a decoy input), then
  // completes the handshake.
  task automatic run_block(input int sel, input logic [127:0] st_i,
                           input logic [127:0] key_i, input logic last_i,
                           input logic [127:0] exp_i, input int lat_i,
                           input int hold_i, input string name);
    int n;
    logic [127:0] held;
    st = st_i; key = key_i; last = last_i;
    out_ready[sel] = 1'b0;
    in_valid[sel] = 1'b1;
    checks++;
    if (in_ready[sel] !== 1'b1) begin
      errors++; $display("FAIL %s_ready_before: got %b expected 1", name, in_ready[sel]);
    end
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    n = 1;
    while (out_valid[sel] !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== lat_i) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, lat_i);
    end
    checks++;
    if (out_valid[sel] !== 1'b1) begin
      errors++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid[sel]);
    end
    checks++;
    if (next_state[sel] !== exp_i) begin
      errors++; $display("FAIL %s_result: got %h expected %h", name, next_state[sel], exp_i);
    end
    held = next_state[sel];
    if (hold_i > 0) begin
      st = ~st_i; key = 128'h5a5a; last = 1'b1;
      in_valid[sel] = 1'b1;
      for (int i = 0; i < hold_i; i++) begin
        @(posedge clk); #1;
        checks++;
        if (next_state[sel] !== exp_i || out_valid[sel] !== 1'b1 || in_ready[sel] !== 1'b0) begin
          errors++;
          $display("FAIL %s_hold%0d: got ns=%h ov=%b ir=%b expected ns=%h ov=1 ir=0",
                   name, i, next_state[sel], out_valid[sel], in_ready[sel], exp_i);
        end
      end
      in_valid[sel] = 1'b0;
    end
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    checks++;
    if (out_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1) begin
      errors++; $display("FAIL %s_handshake: got ov=%b ir=%b expected ov=0 ir=1",
                         name, out_valid[sel], in_ready[sel]);
    end
    checks++;
    if (next_state[sel] !== held) begin
      errors++; $display("FAIL %s_keep: got %h expected %h", name, next_state[sel], held);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3 reset = 1'b1;   // asynchronous assert before the first clock edge
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || next_state[d] !== 128'h0) begin
        errors++; $display("FAIL reset_state%0d: got ov=%b ir=%b ns=%h expected ov=0 ir=1 ns=0",
                           d, out_valid[d], in_ready[d], next_state[d]);
      end
    end
    @(posedge clk); #3;
    reset = 1'b0;      // release mid-cycle
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL reset_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_mix();
    run_block(0, C_ST2, 128'h0, 1'b0, C_EXP2, 5, 0, "mix_c1");
    run_block(0, ~C_ST2, {128{1'b1}}, 1'b0, C_EXP2, 5, 0, "mix_keyed_c1");
  endtask

  task automatic test_last_round();
    run_block(0, C_ST4, C_KEY4, 1'b1, C_EXP4, 1, 0, "last_c1");
  endtask

  task automatic test_backpressure();
    run_block(0, C_ST2, 128'h0, 1'b0, C_EXP2, 5, 10, "bp_c1");
    // The decoy offered during DONE must not have been accepted.
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_no_accept: got ov=%b ir=%b expected ov=0 ir=1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_mid_mix();
    st = C_ST2; key = 128'h0; last = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;   // column 0
    @(posedge clk); #1;   // column 1
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL midmix_busy: got ir=%b expected 0", in_ready[0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || next_state[0] !== 128'h0) begin
      errors++; $display("FAIL midmix_reset: got ir=%b ov=%b ns=%h expected ir=1 ov=0 ns=0",
                         in_ready[0], out_valid[0], next_state[0]);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid[0] !== 1'b0) begin
        errors++; $display("FAIL midmix_no_output%0d: got ov=%b expected 0", i, out_valid[0]);
      end
      @(posedge clk); #1;
    end
    run_block(0, C_ST2, 128'h0, 1'b0, C_EXP2, 5, 0, "after_reset_c1");
  endtask

  task automatic test_cols2();
    run_block(1, C_ST2, 128'h0, 1'b0, C_EXP2, 3, 0, "mix_c2");
    run_block(1, ~C_ST2, {128{1'b1}}, 1'b0, C_EXP2, 3, 0, "mix_keyed_c2");
    run_block(1, C_ST4, C_KEY4, 1'b1, C_EXP4, 1, 0, "last_c2");
  endtask

  task automatic test_cols4();
    run_block(2, C_ST2, 128'h0, 1'b0, C_EXP2, 2, 0, "mix_c4");
    run_block(2, ~C_ST2, {128{1'b1}}, 1'b0, C_EXP2, 2, 0, "mix_keyed_c4");
    run_block(2, C_ST4, C_KEY4, 1'b1, C_EXP4, 1, 0, "last_c4");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    st = '0; key = '0; last = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_mix();
    test_last_round();
    test_backpressure();
    test_reset_mid_mix();
    test_cols2();
    test_cols4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
